// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: load/store controller with alignment check, byte-lane steering and sub-word read-modify-write
// Optional feature: DATA_MEMORY_MMIO_EN maps word accesses at 0xFFFF_FFF0 to the io_out register.
module data_memory_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_SIZE  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [1:0]           size,
    input  logic [31:0]          address,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WORD_SIZE-1:0] io_out
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

    state_t                st;
    logic [WORD_SIZE-1:0]  mem [0:(1<<ADDR_WIDTH)-1];
    logic [WORD_SIZE-1:0]  ram_q, l_wdata, wr_word, mask, merged;
    logic [ADDR_WIDTH-1:0] l_idx, ram_addr;
    logic [1:0]            l_lane, l_size;
    logic [4:0]            shamt;
    logic                  l_we, l_mmio, is_word, misaligned, mmio_hit;
    logic                  unused_addr;

`ifdef DATA_MEMORY_MMIO_EN
    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;
    assign mmio_hit = address == MMIO_ADDR;
`else
    assign mmio_hit = 1'b0;
`endif

    // Upper address bits only matter for the MMIO decode; RAM addresses wrap
    assign unused_addr = &{1'b0, address[31:ADDR_WIDTH+2]};

    // Alignment check and lane steering for the sub-word merge
    always_comb begin
        is_word    = size == 2'b11 || size == 2'b00;
        misaligned = (size == 2'b10 && address[0]) || (is_word && address[1:0] != 2'b00) || (mmio_hit && !is_word);
        ram_addr   = st == IDLE ? address[ADDR_WIDTH+1:2] : l_idx;
        shamt      = {l_lane, 3'b000};
        mask       = l_size == 2'b01 ? WORD_SIZE'(8'hFF) << shamt : WORD_SIZE'(16'hFFFF) << shamt;
        merged     = (ram_q & ~mask) | ((l_wdata << shamt) & mask);
    end

    // Synchronous RAM; a write still pending when reset hits is dropped
    always_ff @(posedge clk) begin
        ram_q <= mem[ram_addr];
        if (rst && st == WR && !l_mmio) mem[l_idx] <= wr_word;
    end

    // Request sequencing with registered busy/done/error/rdata
    always_ff @(posedge clk) begin
        if (!rst) begin
            st    <= IDLE;
            rdata <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: if (req) begin
                    l_we    <= we;
                    l_size  <= size;
                    l_lane  <= address[1:0];
                    l_idx   <= address[ADDR_WIDTH+1:2];
                    l_wdata <= wdata;
                    l_mmio  <= mmio_hit;
                    wr_word <= wdata;
                    error   <= misaligned;
                    busy    <= 1'b1;
                    done    <= misaligned;
                    st      <= misaligned ? RESP : (we && is_word) ? WR : RD_WAIT;
                end
                RD_WAIT: begin
                    if (!l_we) rdata <= l_mmio ? io_out : ram_q >> shamt;
                    wr_word <= merged;
                    done    <= !l_we;
                    st      <= l_we ? WR : RESP;
                end
                WR: begin
                    done <= 1'b1;
                    st   <= RESP;
                end
                RESP: begin
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef DATA_MEMORY_MMIO_EN
    // Memory-mapped output register, updated by word stores at the WR exit edge
    always_ff @(posedge clk) begin
        if (!rst) io_out <= '0;
        else if (st == WR && l_mmio) io_out <= wr_word;
    end
`else
    assign io_out = '0;
`endif
endmodule
